// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer producing the full ALUSystem control word each cycle.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes halt the sequencer instead of executing as NOP.
module control_sequencer #(
  parameter logic [3:0]  HALT_OPC = 4'hB,
  parameter int unsigned SC_W     = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [15:0]     IR_Out,
  input  logic [3:0]      ALU_Flags,
  output logic [40:0]     CtrlWord,
  output logic [SC_W-1:0] SeqCnt,
  output logic            Halted,
  output logic            Illegal
);

  typedef struct packed {
    logic [2:0] rf_o1_sel;
    logic [2:0] rf_o2_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_r_sel;
    logic [3:0] rf_t_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_out_a_sel;
    logic [1:0] arf_out_b_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_r_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_fun_sel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  // S_IDLE is the post-reset state that has not yet issued its first fetch.
  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_HALT} state_t;

  localparam logic [SC_W-1:0] SC_T0 = SC_W'(0);
  localparam logic [SC_W-1:0] SC_T1 = SC_W'(1);
  localparam logic [SC_W-1:0] SC_T2 = SC_W'(2);

  state_t state_r;
  logic   illegal_opc_s;

  function automatic ctrl_t idle_word();
    ctrl_t w;
    w        = '0;
    w.mem_cs = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t fetch_word(input logic lh);
    ctrl_t w;
    w               = '0;
    w.arf_out_b_sel = 2'b10;
    w.mem_cs        = 1'b0;
    w.mem_wr        = 1'b0;
    w.ir_enable     = 1'b1;
    w.ir_lh         = lh;
    w.ir_fun_sel    = 2'b01;
    w.arf_r_sel     = 4'b0010;
    w.arf_fun_sel   = 2'b10;
    return w;
  endfunction

  function automatic logic [3:0] reg_onehot(input logic [1:0] r);
    return 4'b1000 >> r;
  endfunction

  function automatic logic [3:0] alu_code(input logic [2:0] op);
    logic [3:0] c;
    case (op)
      3'd0:    c = 4'b0111;
      3'd1:    c = 4'b1000;
      3'd2:    c = 4'b0010;
      3'd3:    c = 4'b0100;
      3'd4:    c = 4'b0110;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b1011;
      3'd7:    c = 4'b0000;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  function automatic ctrl_t exec_word(input logic [15:0] ir, input logic z);
    ctrl_t w;
    w = idle_word();
    case (ir[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        w.rf_o1_sel   = {1'b1, ir[9:8]};
        w.rf_o2_sel   = {1'b1, ir[7:6]};
        w.mux_c_sel   = 1'b0;
        w.alu_fun_sel = alu_code(ir[14:12]);
        w.mux_a_sel   = 2'b00;
        w.rf_r_sel    = reg_onehot(ir[11:10]);
        w.rf_fun_sel  = 2'b01;
      end
      4'h8, 4'h9: begin
        // BNE falls through to IDLE when Z is set.
        if ((ir[15:12] == 4'h8) || !z) begin
          w.mux_b_sel   = 2'b10;
          w.arf_r_sel   = 4'b0010;
          w.arf_fun_sel = 2'b01;
        end else begin
          w = idle_word();
        end
      end
      4'hA: begin
        w.mux_a_sel  = 2'b10;
        w.rf_r_sel   = reg_onehot(ir[11:10]);
        w.rf_fun_sel = 2'b01;
      end
      default: w = idle_word();
    endcase
    return w;
  endfunction

  assign illegal_opc_s = (IR_Out[15:12] >= 4'hC) && (IR_Out[15:12] != HALT_OPC);

  // Sequence-counter FSM with registered control word and status outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r  <= S_IDLE;
      CtrlWord <= idle_word();
      SeqCnt   <= SC_T0;
      Halted   <= 1'b0;
      Illegal  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_T2: begin
          state_r  <= S_T0;
          CtrlWord <= fetch_word(1'b0);
          SeqCnt   <= SC_T0;
        end
        S_T0: begin
          state_r  <= S_T1;
          CtrlWord <= fetch_word(1'b1);
          SeqCnt   <= SC_T1;
        end
        S_T1: begin
          SeqCnt <= SC_T2;
          if (IR_Out[15:12] == HALT_OPC) begin
            state_r  <= S_HALT;
            CtrlWord <= idle_word();
            Halted   <= 1'b1;
          end else if (illegal_opc_s) begin
            CtrlWord <= idle_word();
            Illegal  <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
            state_r  <= S_HALT;
            Halted   <= 1'b1;
`else
            state_r  <= S_T2;
`endif
          end else begin
            state_r  <= S_T2;
            CtrlWord <= exec_word(IR_Out, ALU_Flags[3]);
          end
        end
        S_HALT: begin
          state_r  <= S_HALT;
          CtrlWord <= idle_word();
          SeqCnt   <= SC_T2;
          Halted   <= 1'b1;
        end
        default: begin
          state_r  <= S_IDLE;
          CtrlWord <= idle_word();
          SeqCnt   <= SC_T0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table plus reset/halt/illegal sequences,
// with a scoreboard queue of expected per-cycle outputs.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IR_Out;
  logic [3:0]  ALU_Flags;
  logic [40:0] CtrlWord;
  logic [1:0]  SeqCnt;
  logic        Halted;
  logic        Illegal;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out), .ALU_Flags(ALU_Flags),
    .CtrlWord(CtrlWord), .SeqCnt(SeqCnt), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [40:0] w; logic [1:0] sc; logic h; logic il; } exp_t;
  typedef struct { logic [15:0] ir; logic [3:0] flags; logic [40:0] w; } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic ill_m    = 1'b0;

  // Field order MSB first: O1,O2,RF_Fun,RF_R,RF_T,ALU,ARF_A,ARF_B,ARF_Fun,ARF_R,LH,IREn,IRFun,WR,CS,MuxA,MuxB,MuxC
  function automatic logic [40:0] pack_w(logic [2:0] o1, logic [2:0] o2, logic [1:0] rff,
      logic [3:0] rrs, logic [3:0] alu, logic [1:0] outb, logic [1:0] arff, logic [3:0] arfr,
      logic lh, logic ire, logic [1:0] irf, logic cs, logic [1:0] muxa, logic [1:0] muxb);
    return {o1, o2, rff, rrs, 4'b0000, alu, 2'b00, outb, arff, arfr, lh, ire, irf, 1'b0, cs,
            muxa, muxb, 1'b0};
  endfunction

  function automatic logic [40:0] w_idle();
    return pack_w(3'd0, 3'd0, 2'd0, 4'd0, 4'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0);
  endfunction
  function automatic logic [40:0] w_fetch(logic lh);
    return pack_w(3'd0, 3'd0, 2'd0, 4'd0, 4'd0, 2'b10, 2'b10, 4'b0010, lh, 1'b1, 2'b01, 1'b0,
                  2'd0, 2'd0);
  endfunction
  function automatic logic [40:0] w_alu(logic [2:0] o1, logic [2:0] o2, logic [3:0] rs,
      logic [3:0] alu);
    return pack_w(o1, o2, 2'b01, rs, alu, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b00, 2'd0);
  endfunction
  function automatic logic [40:0] w_bra();
    return pack_w(3'd0, 3'd0, 2'd0, 4'd0, 4'd0, 2'd0, 2'b01, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1,
                  2'd0, 2'b10);
  endfunction
  function automatic logic [40:0] w_ldi(logic [3:0] rs);
    return pack_w(3'd0, 3'd0, 2'b01, rs, 4'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1,
                  2'b10, 2'd0);
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [40:0] w, input logic [1:0] sc, input logic h, input logic il);
    exp_t e;
    e.w = w; e.sc = sc; e.h = h; e.il = il;
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty cycle=%0d", cyc);
    end else begin
      e = sb_q.pop_front();
      cmp("CtrlWord", 64'(CtrlWord), 64'(e.w));
      cmp("SeqCnt",   64'(SeqCnt),   64'(e.sc));
      cmp("Halted",   64'(Halted),   64'(e.h));
      cmp("Illegal",  64'(Illegal),  64'(e.il));
    end
  endtask

  task automatic step();
    @(negedge Clock);
    cyc++;
    check_now();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    ill_m = 1'b0;
    @(negedge Clock);
    push(w_idle(), 2'd0, 1'b0, 1'b0);
    check_now();
    Reset = 1'b0;
  endtask

  // One full instruction: IR is valid only in T1 (sampled on the edge into T2); garbage elsewhere.
  task automatic run_instr(input logic [15:0] ir, input logic [3:0] flags,
                           input logic [40:0] exp_w, input logic exp_h, input logic exp_il);
    push(w_fetch(1'b0), 2'd0, 1'b0, ill_m);
    step();
    IR_Out = 16'hB000;
    push(w_fetch(1'b1), 2'd1, 1'b0, ill_m);
    step();
    IR_Out    = ir;
    ALU_Flags = flags;
    ill_m     = exp_il;
    push(exp_w, 2'd2, exp_h, ill_m);
    step();
    IR_Out    = 16'hB000;
    ALU_Flags = ~flags;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    IR_Out    = 16'h0000;
    ALU_Flags = 4'h0;

    vecs[0]  = '{16'h3180, 4'h0, w_alu(3'b101, 3'b110, 4'b1000, 4'b0100)};
    vecs[1]  = '{16'h0E40, 4'h0, w_alu(3'b110, 3'b101, 4'b0001, 4'b0111)};
    vecs[2]  = '{16'h1700, 4'hF, w_alu(3'b111, 3'b100, 4'b0100, 4'b1000)};
    vecs[3]  = '{16'h28C0, 4'h0, w_alu(3'b100, 3'b111, 4'b0010, 4'b0010)};
    vecs[4]  = '{16'h4000, 4'h0, w_alu(3'b100, 3'b100, 4'b1000, 4'b0110)};
    vecs[5]  = '{16'h5500, 4'h0, w_alu(3'b101, 3'b100, 4'b0100, 4'b1010)};
    vecs[6]  = '{16'h6A40, 4'h0, w_alu(3'b110, 3'b101, 4'b0010, 4'b1011)};
    vecs[7]  = '{16'h7FC0, 4'h0, w_alu(3'b111, 3'b111, 4'b0001, 4'b0000)};
    vecs[8]  = '{16'h8012, 4'h8, w_bra()};
    vecs[9]  = '{16'h9042, 4'h8, w_idle()};
    vecs[10] = '{16'h9042, 4'h7, w_bra()};
    vecs[11] = '{16'hA855, 4'h0, w_ldi(4'b0010)};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i].ir, vecs[i].flags, vecs[i].w, 1'b0, ill_m);
    end

    // Reset asserted in the middle of T1 must force IDLE immediately.
    push(w_fetch(1'b0), 2'd0, 1'b0, ill_m);
    step();
    push(w_fetch(1'b1), 2'd1, 1'b0, ill_m);
    step();
    Reset = 1'b1;
    ill_m = 1'b0;
    #1;
    push(w_idle(), 2'd0, 1'b0, 1'b0);
    check_now();
    @(negedge Clock);
    Reset = 1'b0;
    run_instr(16'h3180, 4'h0, w_alu(3'b101, 3'b110, 4'b1000, 4'b0100), 1'b0, 1'b0);

`ifdef ILLEGAL_TRAP_EN
    run_instr(16'hE000, 4'h0, w_idle(), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push(w_idle(), 2'd2, 1'b1, 1'b1);
      step();
    end
`else
    run_instr(16'hE000, 4'h0, w_idle(), 1'b0, 1'b1);
    run_instr(16'h5500, 4'h0, w_alu(3'b101, 3'b100, 4'b0100, 4'b1010), 1'b0, 1'b1);
    run_instr(16'hC123, 4'h0, w_idle(), 1'b0, 1'b1);
    run_instr(16'hA855, 4'h0, w_ldi(4'b0010), 1'b0, 1'b1);
`endif

    do_reset();
    run_instr(16'hB000, 4'h0, w_idle(), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      IR_Out = 16'h3180;
      push(w_idle(), 2'd2, 1'b1, 1'b0);
      step();
    end

    do_reset();
    run_instr(16'h0E40, 4'h0, w_alu(3'b110, 3'b101, 4'b0001, 4'b0111), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
